// File: rtl/msj_feedback_pkg.sv
// Shared types and the quadrature step decoder for the MSJ joint feedback stage.
package msj_feedback_pkg;
  typedef logic [1:0] quad_state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t;
  typedef enum logic {DEC_INIT, DEC_TRACK} dec_state_t;

  // Position of {a,b} along the forward Gray cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] quad_phase(input quad_state_t s);
    logic [1:0] p;
    case (s)
      2'b00:   p = 2'd0;
      2'b10:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  function automatic step_t quad_step(input quad_state_t prev, input quad_state_t curr);
    logic [1:0] d;
    step_t      s;
    d = quad_phase(curr) - quad_phase(prev);
    case (d)
      2'd0:    s = STEP_NONE;
      2'd1:    s = STEP_FWD;
      2'd3:    s = STEP_REV;
      default: s = STEP_ILLEGAL;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer plus glitch filter for the encoder pair; a new {a,b}
// is accepted only after it has been seen for FILTER_LEN consecutive cycles.
module quad_input_filter
  import msj_feedback_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [1:0]  raw_i,
  output quad_state_t state_o,
  output logic        changed_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  quad_state_t   sync1_q, sync2_q, cand_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] hit_d;
  logic          changed_q;

  // Run length of the candidate, restarting at 1 when the candidate itself changes.
  always_comb begin
    hit_d = CW'(1);
    if (cnt_q == '0 || sync2_q == cand_q) hit_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      changed_q <= 1'b0;
      if (sync2_q == acc_q) begin
        cnt_q <= '0;
      end else if (hit_d == CW'(FILTER_LEN)) begin
        acc_q     <= sync2_q;
        changed_q <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q  <= hit_d;
        cand_q <= sync2_q;
      end
    end
  end

  assign state_o   = acc_q;
  assign changed_o = changed_q;
endmodule

// File: rtl/msj_quadrature_feedback.sv
// Quadrature encoder feedback for one MSJ joint: position count, per-period
// velocity and the periodic controller update strobe.
module msj_quadrature_feedback
  import msj_feedback_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int UPDATE_HZ   = 1000,
  parameter int FILTER_LEN  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               invert_direction,
  input  logic               load_position,
  input  logic signed [31:0] load_value,
  output logic signed [31:0] position,
  output logic signed [31:0] velocity,
  output logic               update_controller,
  output logic [15:0]        error_count
);
  localparam int UPDATE_DIV = CLK_FREQ_HZ / UPDATE_HZ;
  localparam int PW         = $clog2(UPDATE_DIV);

  quad_state_t        acc;
  logic               changed;
  dec_state_t         dec_state_q;
  quad_state_t        prev_q;
  step_t              step_q;
  logic signed [31:0] count_q, ref_q, position_q, velocity_q;
  logic signed [31:0] count_d, ref_base, delta;
  logic [15:0]        error_q, error_d;
  logic [PW-1:0]      period_q;
  logic               update_q, terminal;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clock_i   (clock),
    .reset_i   (reset),
    .raw_i     ({enc_a, enc_b}),
    .state_o   (acc),
    .changed_o (changed)
  );

  // Decode FSM: the first accepted state after reset is only a reference.
  always_ff @(posedge clock) begin
    if (reset) begin
      dec_state_q <= DEC_INIT;
      prev_q      <= '0;
      step_q      <= STEP_NONE;
    end else begin
      step_q <= STEP_NONE;
      if (changed) begin
        prev_q <= acc;
        case (dec_state_q)
          DEC_INIT:  dec_state_q <= DEC_TRACK;
          DEC_TRACK: step_q      <= quad_step(prev_q, acc);
          default:   dec_state_q <= DEC_INIT;
        endcase
      end
    end
  end

  always_comb begin
    delta = '0;
    case (step_q)
      STEP_FWD: delta = invert_direction ? -32'sd1 : 32'sd1;
      STEP_REV: delta = invert_direction ? 32'sd1 : -32'sd1;
      default:  delta = '0;
    endcase
    // A load wins over a concurrent step and re-bases the velocity reference.
    count_d  = load_position ? load_value : count_q + delta;
    ref_base = load_position ? load_value : ref_q;
    error_d  = error_q;
    if (step_q == STEP_ILLEGAL && error_q != 16'hFFFF) error_d = error_q + 16'd1;
    terminal = (period_q == PW'(UPDATE_DIV - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      ref_q      <= '0;
      position_q <= '0;
      velocity_q <= '0;
      error_q    <= '0;
      period_q   <= '0;
      update_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      error_q  <= error_d;
      update_q <= terminal;
      period_q <= terminal ? '0 : period_q + 1'b1;
      if (terminal) begin
        position_q <= count_d;
        velocity_q <= count_d - ref_base;
        ref_q      <= count_d;
      end else begin
        ref_q <= ref_base;
      end
    end
  end

  assign position          = position_q;
  assign velocity          = velocity_q;
  assign update_controller = update_q;
  assign error_count       = error_q;
endmodule

// File: tb/tb_msj_quadrature_feedback.sv
// Directed bench for msj_quadrature_feedback (UPDATE_DIV=10, FILTER_LEN=2) plus a
// FILTER_LEN=1 instance used to drive the error counter into saturation quickly.
module tb_msj_quadrature_feedback;
  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enc_a = 1'b1;
  logic               enc_b = 1'b1;
  logic               invert_direction = 1'b0;
  logic               load_position = 1'b0;
  logic signed [31:0] load_value = '0;
  logic signed [31:0] position, velocity;
  logic               update_controller;
  logic [15:0]        error_count;

  logic               rst_fast = 1'b1;
  logic [1:0]         fast_ab = 2'b00;
  logic signed [31:0] fast_pos, fast_vel;
  logic               fast_upd;
  logic [15:0]        fast_err;

  int          checks = 0;
  int          failures = 0;
  int          vsum = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  cur_ab = 2'b11;

  msj_quadrature_feedback #(.CLK_FREQ_HZ(1000), .UPDATE_HZ(100), .FILTER_LEN(2)) dut (
    .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .invert_direction(invert_direction), .load_position(load_position),
    .load_value(load_value), .position(position), .velocity(velocity),
    .update_controller(update_controller), .error_count(error_count)
  );

  msj_quadrature_feedback #(.CLK_FREQ_HZ(1000), .UPDATE_HZ(100), .FILTER_LEN(1)) dut_fast (
    .clock(clock), .reset(rst_fast), .enc_a(fast_ab[1]), .enc_b(fast_ab[0]),
    .invert_direction(1'b0), .load_position(1'b0), .load_value(32'sd0),
    .position(fast_pos), .velocity(fast_vel), .update_controller(fast_upd),
    .error_count(fast_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (update_controller) vsum = vsum + velocity;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_ab(input logic [1:0] v);
    @(negedge clock);
    {enc_a, enc_b} = v;
    cur_ab = v;
  endtask

  task automatic step_fwd();
    drive_ab(next_fwd(cur_ab));
    repeat (11) @(posedge clock);
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!update_controller && n < 40);
    if (!update_controller) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_strobe(input string tag);
    logic [31:0] ep, ev;
    ep = exp_q.pop_front();
    ev = exp_q.pop_front();
    wait_strobe();
    chk({tag, "_pos"}, position, ep);
    chk({tag, "_vel"}, velocity, ev);
  endtask

  task automatic check_first_strobe(input string tag);
    int first;
    first = 0;
    for (int i = 1; i <= 14 && first == 0; i++) begin
      @(posedge clock);
      #1;
      if (update_controller) first = i;
    end
    chk({tag, "_cycle"}, first, 32'd10);
    chk({tag, "_pos"}, position, 32'd0);
    chk({tag, "_vel"}, velocity, 32'd0);
  endtask

  task automatic main_sequence();
    int v0;
    // Reset values and first strobe with the encoder parked at 11.
    {enc_a, enc_b} = 2'b11;
    repeat (4) @(posedge clock);
    #1;
    chk("rst_position", position, 32'd0);
    chk("rst_velocity", velocity, 32'd0);
    chk("rst_error", error_count, 32'd0);
    chk("rst_update", update_controller, 32'd0);
    @(negedge clock) reset = 1'b0;
    check_first_strobe("first");
    @(posedge clock); #1;
    chk("strobe_width", update_controller, 32'd0);
    repeat (8) @(posedge clock); #1;
    chk("period_gap", update_controller, 32'd0);
    @(posedge clock); #1;
    chk("period_10", update_controller, 32'd1);

    // Eight forward steps.
    v0 = vsum;
    for (int i = 0; i < 8; i++) step_fwd();
    repeat (25) @(posedge clock);
    wait_strobe(); #1;
    chk("fwd_position", position, 32'd8);
    chk("fwd_vel_sum", vsum - v0, 32'd8);

    // Mid-period reset, then the same steps with direction inverted.
    @(negedge clock);
    reset = 1'b1;
    invert_direction = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("rst2_position", position, 32'd0);
    @(negedge clock) reset = 1'b0;
    v0 = vsum;
    check_first_strobe("rst2_first");
    for (int i = 0; i < 8; i++) step_fwd();
    repeat (25) @(posedge clock);
    wait_strobe(); #1;
    chk("inv_position", position, -32'sd8);
    chk("inv_vel_sum", vsum - v0, -32'sd8);
    @(negedge clock) invert_direction = 1'b0;

    // Short glitch is rejected; a 3-cycle pulse counts +1 then -1.
    @(negedge clock) enc_a = 1'b0;
    @(negedge clock) enc_a = 1'b1;
    repeat (10) @(posedge clock); #1;
    chk("glitch1_count", dut.count_q, -32'sd8);
    chk("glitch1_err", error_count, 32'd0);
    @(negedge clock) {enc_a, enc_b} = 2'b01;
    repeat (3) @(posedge clock);
    @(negedge clock) {enc_a, enc_b} = 2'b11;
    repeat (2) @(posedge clock); #1;
    chk("latency_e5", dut.count_q, -32'sd8);
    @(posedge clock); #1;
    chk("latency_e6", dut.count_q, -32'sd7);
    repeat (2) @(posedge clock); #1;
    chk("pulse3_hold", dut.count_q, -32'sd7);
    @(posedge clock); #1;
    chk("pulse3_back", dut.count_q, -32'sd8);
    chk("pulse3_err", error_count, 32'd0);
    wait_strobe();
    chk("pulse3_position", position, -32'sd8);

    // Illegal 00 -> 11.
    step_fwd();
    step_fwd();
    repeat (10) @(posedge clock);
    drive_ab(2'b11);
    repeat (12) @(posedge clock); #1;
    chk("illegal_err", error_count, 32'd1);
    chk("illegal_count", dut.count_q, -32'sd6);
    wait_strobe();
    wait_strobe();
    chk("illegal_position", position, -32'sd6);
    chk("illegal_velocity", velocity, 32'd0);

    // Load near the top of the range, then wrap with one forward step.
    wait_strobe();
    load_value = 32'sh7FFF_FFFF;
    load_position = 1'b1;
    @(negedge clock);
    load_position = 1'b0;
    {enc_a, enc_b} = 2'b01;
    cur_ab = 2'b01;
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'd1);
    expect_strobe("wrap");

    // Load coincident with a step and with terminal count.
    wait_strobe();
    repeat (4) @(posedge clock);
    @(negedge clock) {enc_a, enc_b} = 2'b00;
    cur_ab = 2'b00;
    repeat (5) @(posedge clock);
    @(negedge clock);
    load_value = 32'sd100;
    load_position = 1'b1;
    @(posedge clock);
    @(negedge clock);
    load_position = 1'b0;
    chk("coload_update", update_controller, 32'd1);
    chk("coload_position", position, 32'd100);
    chk("coload_velocity", velocity, 32'd0);
    chk("coload_count", dut.count_q, 32'd100);
    drive_ab(next_fwd(cur_ab));
    exp_q.push_back(32'd101);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd101);
    exp_q.push_back(32'd0);
    expect_strobe("after_load");
    expect_strobe("idle_period");
  endtask

  task automatic fast_saturation();
    repeat (3) @(posedge clock);
    @(negedge clock) rst_fast = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      fast_ab = ~fast_ab;
    end
    repeat (8) @(posedge clock); #1;
    chk("fast_err_999", fast_err, 32'd999);
    for (int i = 0; i < 64600; i++) begin
      @(negedge clock);
      fast_ab = ~fast_ab;
    end
    repeat (8) @(posedge clock); #1;
    chk("fast_err_sat", fast_err, 32'h0000_FFFF);
    chk("fast_position", fast_pos, 32'd0);
  endtask

  initial begin
    #1_500_000;
    chk("watchdog", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    fork
      main_sequence();
      fast_saturation();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msj_quadrature_feedback.md
# msj_quadrature_feedback

Upstream feedback stage for one MSJ platform joint. It decodes a quadrature encoder into a signed 32-bit position and computes velocity as counts per control period. It generates the periodic one-cycle `update_controller` strobe that triggers the PD controller. `position`, `velocity` and `update_controller` connect directly to the controller's inputs of the same names.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 50_000_000: clock frequency.
- `UPDATE_HZ`, default 1000: controller update rate. `UPDATE_DIV = CLK_FREQ_HZ/UPDATE_HZ`, which must be ≥ 4.
- `FILTER_LEN`, default 4: number of consecutive stable cycles required before an input change is accepted. Must be ≥ 1.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `enc_a`, `enc_b`, in, 1 each: raw encoder channels, asynchronous.
- `invert_direction`, in, 1: negates every decoded step.
- `load_position`, in, 1: single-cycle request to overwrite the count.
- `load_value`, in, 32 signed: value written on load.
- `position`, out, 32 signed: snapshot of the count.
- `velocity`, out, 32 signed: counts per update period.
- `update_controller`, out, 1: one-cycle strobe.
- `error_count`, out, 16: number of illegal transitions, saturating.

## Operation
- Input path: 2-FF synchronizer, then glitch filter on the pair `{a,b}`. The accepted state changes only after the synchronized pair holds a new value for `FILTER_LEN` consecutive cycles.
- Decode FSM:
  - INIT: after reset, the first accepted state becomes the reference without counting. Then go to TRACK.
  - TRACK: compare accepted state against the previous one.
    - Forward sequence {a,b}: 00→10→11→01→00 gives +1.
    - Reverse sequence gives −1.
    - Both bits changed: illegal. Position is unchanged and `error_count` increments, saturating at 0xFFFF.
  - `invert_direction` swaps +1 and −1.
- Counter: internal 32-bit two's-complement `count`, wraps freely (0x7FFFFFFF + 1 = 0x80000000).
- Load: `load_position` sets `count <= load_value` and `ref <= load_value`. Load beats a simultaneous step; that step is discarded.
- Period counter runs 0..UPDATE_DIV−1. At terminal count:
  - `position <= count_next`
  - `velocity <= count_next − ref`, 32-bit wrapping subtraction, so it is correct across wrap.
  - `ref <= count_next`
  - `update_controller <= 1` for exactly one cycle.
- Load coinciding with terminal count: `position = load_value`, `velocity = 0`.

## Timing
- Reset values:
  - `position`, `velocity`, `error_count` = 0.
  - `update_controller` = 0.
  - Period counter = 0, FSM in INIT.
  - Synchronizer and filter registers = 0.
- A change of `{enc_a,enc_b}` held stable updates internal `count` exactly `FILTER_LEN + 3` cycles after the first sampling edge.
- The first `update_controller` pulse occurs at `UPDATE_DIV` cycles after reset deassertion. Pulses then occur every `UPDATE_DIV` cycles with no jitter; load does not reset the period counter.
- `position` and `velocity` change only in the cycle `update_controller` is high and are valid in that same cycle. They are held until the next strobe.
- Reset asserted mid-period or mid-filter aborts everything. No strobe is emitted while reset is high.

## Structure
- Package `msj_feedback_pkg`:
  - `typedef logic [1:0] quad_state_t`
  - `enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t`
  - `enum {DEC_INIT, DEC_TRACK} dec_state_t`
  - function `quad_step(prev, curr)` returning `step_t`
- Sub-module `quad_input_filter`: 2-bit synchronizer plus glitch filter, parameterized by `FILTER_LEN`. Outputs the accepted state and a one-cycle `changed` pulse.

## Test plan
All scenarios use CLK_FREQ_HZ=1000, UPDATE_HZ=100 (UPDATE_DIV=10), FILTER_LEN=2.
1. Inputs held at 11 through reset release → no count; first strobe at cycle 10 with `position=0`, `velocity=0`.
2. 8 forward transitions spaced 12 cycles apart → final `position=8`, sum of `velocity` over strobes = 8. Repeat with `invert_direction=1` → `position=−8`.
3. 1-cycle pulse on `enc_a` (shorter than FILTER_LEN) → count unchanged and no error. A 3-cycle pulse gives +1 then −1.
4. Forced 00→11 transition → `error_count=1`, `position` unchanged. 65 536 further illegal transitions → `error_count` stays 0xFFFF.
5. Load 0x7FFFFFFF, then one forward step → next strobe `position=0x80000000`, `velocity=+1`.
6. `load_position` with `load_value=100` in the same cycle as a step and as terminal count → `position=100`, `velocity=0`; step discarded; next period measures only new steps.
